serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. It adds two WIDTH-bit operands LSB-first, BITS_PER_CYCLE bits per clock, through a ripple slice of 1-bit full-adder cells and a registered carry.
- It generalises the single-bit combinational adder into a width-scalable, area/latency-tradeable arithmetic unit with a start/done handshake.
- It is used wherever a lab datapath needs wide add/sub at low LUT cost.

Parameters:
- WIDTH, 16, operand and result width in bits; must be >= 2.
- BITS_PER_CYCLE, 1, bits processed per clock. Must divide WIDTH; elaboration fails otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation. Sampled only when ready=1.
- sub  input  1  0 computes a+b+cin; 1 computes a-b (a + ~b + 1). cin is ignored when sub=1.
- cin  input  1  carry-in for add mode.
- a  input  WIDTH  operand A, captured on the accepted start.
- b  input  WIDTH  operand B, captured on the accepted start.
- ready  output  1  high when the block can accept start (states IDLE or DONE).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result. Held until the next accepted start.
- cout  output  1  final carry out. In sub mode, 1 means no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: rst=1 is synchronous, active-high, and takes priority over everything.
  - Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0.
  - The internal shift registers, carry register and counter are cleared.
  - Reset mid-RUN aborts the operation. No done pulse is produced.
- Constant K = WIDTH/BITS_PER_CYCLE. Counter width = clog2(K), minimum 1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN.
  - Latch a into shift reg A and (sub ? ~b : b) into shift reg B.
  - Load the carry register with (sub ? 1 : cin). Clear the counter.
- RUN, each cycle:
  - Feed the low BITS_PER_CYCLE bits of A and B, plus the carry register, into the ripple slice.
  - Shift the slice sums into the result register from the MSB side.
  - Shift A and B right by BITS_PER_CYCLE.
  - Carry register <= slice carry-out.
  - Record the carry into the top slice bit on the final cycle for ovf.
- RUN exit: after K RUN cycles (counter == K-1), go to DONE.
  - sum, cout and ovf update on that same edge.
  - done=1 for exactly one cycle, the first cycle in DONE.
- DONE:
  - Outputs are held. done drops after 1 cycle, and the state stays DONE while there is no start.
  - start=1 in DONE behaves exactly like start in IDLE (back-to-back operation). The previous sum is held until the new result is written.
- start while busy=1 is ignored and has no side effects.
- Latency: accepted start at edge N -> done high in the cycle after edge N+K. This gives 1 operation per K+1 cycles; back-to-back throughput is also K+1.
- Width rules:
  - sum is the modulo-2^WIDTH result.
  - cout is bit WIDTH of the (WIDTH+1)-bit true sum of a + b_eff + c0.
  - ovf uses two's-complement interpretation in both modes.
- Operand inputs may change freely after acceptance; the captured copies are used.
- ready = (state != RUN). busy = (state == RUN).

Decomposition:
- Package serial_adder_pkg holds:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a clog2 function used for the counter width.
- Sub-module fa_bit: combinational 1-bit full adder (a, b, c -> sum, carry; sum = a^b^c, carry = majority).
  - Instantiated BITS_PER_CYCLE times in a generate loop as the ripple slice.
  - The carry of slice i feeds slice i+1.
- FSM, counter, shift registers and flags stay in serial_adder.

Test Plan:
- WIDTH=8, BPC=1, add: a=0x5A, b=0x3C, cin=0 -> done pulses 9 cycles after the start edge; sum=0x96, cout=0, ovf=1. busy is high for exactly 8 cycles.
- WIDTH=8, BPC=1, add: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0. Then sub: a=0x10, b=0x20 -> sum=0xF0, cout=0 (borrow), ovf=0.
- WIDTH=16, BPC=4, sub: a=0x8000, b=0x0001 -> done 5 cycles after start; sum=0x7FFF, cout=1, ovf=1.
- Back-to-back: start held high across DONE with new operands 0x0003+0x0004 (W=8, BPC=2) -> second done exactly 5 cycles after the first. sum holds the previous result until the second done, then becomes 0x07.
- Ignored start: pulse start with a=0xAA mid-RUN -> the current result is unaffected, no extra done, and ready stays 0 until DONE.
- Reset mid-RUN: assert rst for 1 cycle at RUN cycle 3 -> next cycle all outputs are 0 with ready=1, and no done pulse. A subsequent start with a=1, b=1 completes normally with sum=2.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the multi-cycle serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v != 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Combinational 1-bit full adder cell used to build the ripple slice.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB first,
// through a ripple slice of full adders and a registered carry.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned K     = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (clog2(K) < 1) ? 1 : clog2(K);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
        $error("serial_adder: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic [BITS_PER_CYCLE-1:0] slice_sum;
    logic [BITS_PER_CYCLE:0]   c_chain;
    logic [WIDTH-1:0]          res_shift_c;

    // Ripple slice: carry of cell i feeds cell i+1, seeded by the carry register.
    assign c_chain[0] = carry_q;
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_slice
        fa_bit u_fa (
            .a    (a_q[i]),
            .b    (b_q[i]),
            .c    (c_chain[i]),
            .sum  (slice_sum[i]),
            .carry(c_chain[i+1])
        );
    end

    // Slice sums enter the result from the MSB side so the LSB slice ends at bit 0.
    if (K == 1) begin : g_single
        assign res_shift_c = slice_sum;
    end else begin : g_multi
        assign res_shift_c = {slice_sum, res_q[WIDTH-1:BITS_PER_CYCLE]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> BITS_PER_CYCLE;
                b_d     = b_q >> BITS_PER_CYCLE;
                res_d   = res_shift_c;
                carry_d = c_chain[BITS_PER_CYCLE];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    // Final slice holds the MSB: its top carry-in/out define ovf.
                    state_d = DONE;
                    sum_d   = res_shift_c;
                    cout_d  = c_chain[BITS_PER_CYCLE];
                    ovf_d   = c_chain[BITS_PER_CYCLE-1] ^ c_chain[BITS_PER_CYCLE];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d != RUN);
        busy_d  = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder across three width/slice configurations.
module tb_serial_adder;

    localparam int KK [3] = '{8, 4, 4};

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        st0, sb0, ci0;
    logic [7:0]  a0, b0, s0;
    logic        st1, sb1, ci1;
    logic [15:0] a1, b1, s1;
    logic        st2, sb2, ci2;
    logic [7:0]  a2, b2, s2;

    logic [15:0] o_sum   [3];
    logic        o_ready [3];
    logic        o_busy  [3];
    logic        o_done  [3];
    logic        o_cout  [3];
    logic        o_ovf   [3];

    assign o_sum[0] = {8'h00, s0};
    assign o_sum[1] = s1;
    assign o_sum[2] = {8'h00, s2};

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_w8b1 (
        .clk(clk), .rst(rst), .start(st0), .sub(sb0), .cin(ci0), .a(a0), .b(b0),
        .ready(o_ready[0]), .busy(o_busy[0]), .done(o_done[0]), .sum(s0),
        .cout(o_cout[0]), .ovf(o_ovf[0])
    );
    serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_w16b4 (
        .clk(clk), .rst(rst), .start(st1), .sub(sb1), .cin(ci1), .a(a1), .b(b1),
        .ready(o_ready[1]), .busy(o_busy[1]), .done(o_done[1]), .sum(s1),
        .cout(o_cout[1]), .ovf(o_ovf[1])
    );
    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_w8b2 (
        .clk(clk), .rst(rst), .start(st2), .sub(sb2), .cin(ci2), .a(a2), .b(b2),
        .ready(o_ready[2]), .busy(o_busy[2]), .done(o_done[2]), .sum(s2),
        .cout(o_cout[2]), .ovf(o_ovf[2])
    );

    // Per-cycle expected output state of one instance
    typedef struct {
        int          at;
        int          inst;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        ready;
        logic        busy;
        logic        done;
    } snap_t;

    // Expected result at a done pulse
    typedef struct {
        int          at;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    snap_t snaps [$];
    res_t  rq0 [$];
    res_t  rq1 [$];
    res_t  rq2 [$];

    logic [15:0] last_sum  [3];
    logic        last_cout [3];
    logic        last_ovf  [3];
    bit          end_req = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    task automatic set_in(input int inst, input logic st, input logic sb, input logic ci,
                          input logic [15:0] av, input logic [15:0] bv);
        case (inst)
            0: begin st0 = st; sb0 = sb; ci0 = ci; a0 = av[7:0]; b0 = bv[7:0]; end
            1: begin st1 = st; sb1 = sb; ci1 = ci; a1 = av;      b1 = bv;      end
            default: begin st2 = st; sb2 = sb; ci2 = ci; a2 = av[7:0]; b2 = bv[7:0]; end
        endcase
    endtask

    task automatic push_snap(input int at, input int inst, input logic [15:0] sm, input logic co,
                             input logic ov, input logic rd, input logic bs, input logic dn);
        snap_t s;
        s.at = at; s.inst = inst; s.sum = sm; s.cout = co; s.ovf = ov;
        s.ready = rd; s.busy = bs; s.done = dn;
        snaps.push_back(s);
    endtask

    // Drive a start at the current negedge; schedule expectations. snap_lim < K models an abort.
    task automatic issue(input int inst, input logic sb, input logic ci,
                         input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] es, input logic ec, input logic eo,
                         input int snap_lim, input bit hold, output int e);
        int   k;
        res_t r;
        k = KK[inst];
        e = cyc + 1;
        set_in(inst, 1'b1, sb, ci, av, bv);
        for (int i = 0; i < k && i < snap_lim; i++)
            push_snap(e + i, inst, last_sum[inst], last_cout[inst], last_ovf[inst], 1'b0, 1'b1, 1'b0);
        if (snap_lim > k) begin
            push_snap(e + k, inst, es, ec, eo, 1'b1, 1'b0, 1'b1);
            r.at = e + k; r.sum = es; r.cout = ec; r.ovf = eo;
            case (inst)
                0: rq0.push_back(r);
                1: rq1.push_back(r);
                default: rq2.push_back(r);
            endcase
            last_sum[inst] = es; last_cout[inst] = ec; last_ovf[inst] = eo;
        end
        if (!hold) begin
            @(negedge clk);
            set_in(inst, 1'b0, ~sb, ~ci, ~av, ~bv);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic run(input int inst, input logic sb, input logic ci,
                       input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] es, input logic ec, input logic eo);
        int e;
        issue(inst, sb, ci, av, bv, es, ec, eo, 99, 1'b0, e);
        wait_until(e + KK[inst] + 1);
    endtask

    initial begin
        int e;
        int e2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(i, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            last_sum[i] = 16'h0; last_cout[i] = 1'b0; last_ovf[i] = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) push_snap(cyc + 1, i, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // W=8, one bit per cycle
        run(0, 1'b0, 1'b0, 16'h005A, 16'h003C, 16'h0096, 1'b0, 1'b1);
        run(0, 1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0000, 1'b1, 1'b0);
        run(0, 1'b1, 1'b1, 16'h0010, 16'h0020, 16'h00F0, 1'b0, 1'b0);
        run(0, 1'b1, 1'b0, 16'h0080, 16'h0001, 16'h007F, 1'b1, 1'b1);
        run(0, 1'b0, 1'b0, 16'h007F, 16'h0001, 16'h0080, 1'b0, 1'b1);

        // Start pulsed mid-RUN must be ignored
        issue(0, 1'b0, 1'b1, 16'h0012, 16'h0034, 16'h0047, 1'b0, 1'b0, 99, 1'b0, e);
        wait_until(e + 2);
        set_in(0, 1'b1, 1'b0, 1'b0, 16'h00AA, 16'h0055);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        wait_until(e + KK[0] + 1);

        // W=16, four bits per cycle
        run(1, 1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
        run(1, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run(1, 1'b0, 1'b1, 16'h1234, 16'h4321, 16'h5556, 1'b0, 1'b0);

        // W=8, two bits per cycle, back-to-back with start held high
        issue(2, 1'b0, 1'b0, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0, 99, 1'b1, e);
        @(negedge clk);
        set_in(2, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0004);
        wait_until(e + KK[2]);
        issue(2, 1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 99, 1'b0, e2);
        wait_until(e2 + KK[2] + 1);
        run(2, 1'b1, 1'b0, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0);

        // Reset during RUN cycle 3 aborts with no done
        issue(0, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 3, 1'b0, e);
        wait_until(e + 2);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_snap(e + 3, i, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            last_sum[i] = 16'h0; last_cout[i] = 1'b0; last_ovf[i] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run(0, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        end_req = 1'b1;
    end

    // Monitor: compares scheduled snapshots and done-time results, then reports
    always @(negedge clk) begin : monitor
        snap_t      s;
        res_t       r;
        bit         have;
        logic [4:0] got;
        logic [4:0] wnt;

        while (snaps.size() > 0 && snaps[0].at <= cyc) begin
            s   = snaps.pop_front();
            got = {o_ready[s.inst], o_busy[s.inst], o_done[s.inst], o_cout[s.inst], o_ovf[s.inst]};
            wnt = {s.ready, s.busy, s.done, s.cout, s.ovf};
            n_chk++;
            if (s.at != cyc || got !== wnt || o_sum[s.inst] !== s.sum) begin
                n_err++;
                $display("FAIL snap u%0d cyc %0d: got rdy/busy/done/cout/ovf=%b sum=%h, want %b sum=%h (sched cyc %0d)",
                         s.inst, cyc, got, o_sum[s.inst], wnt, s.sum, s.at);
            end
        end

        for (int i = 0; i < 3; i++) begin
            if (o_done[i] === 1'b1) begin
                have = 1'b0;
                if (i == 0 && rq0.size() > 0) begin r = rq0.pop_front(); have = 1'b1; end
                if (i == 1 && rq1.size() > 0) begin r = rq1.pop_front(); have = 1'b1; end
                if (i == 2 && rq2.size() > 0) begin r = rq2.pop_front(); have = 1'b1; end
                n_chk++;
                if (!have) begin
                    n_err++;
                    $display("FAIL result u%0d cyc %0d: got unexpected done sum=%h, want no done",
                             i, cyc, o_sum[i]);
                end else if (r.at != cyc || o_sum[i] !== r.sum || o_cout[i] !== r.cout || o_ovf[i] !== r.ovf) begin
                    n_err++;
                    $display("FAIL result u%0d cyc %0d: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b at cyc %0d",
                             i, cyc, o_sum[i], o_cout[i], o_ovf[i], r.sum, r.cout, r.ovf, r.at);
                end
            end
        end

        if (end_req || cyc > 4000) begin
            n_chk++;
            if (!end_req || snaps.size() != 0 || rq0.size() != 0 || rq1.size() != 0 || rq2.size() != 0) begin
                n_err++;
                $display("FAIL drain cyc %0d: got pending snaps=%0d results=%0d/%0d/%0d end=%0b, want all 0 end=1",
                         cyc, snaps.size(), rq0.size(), rq1.size(), rq2.size(), end_req);
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
            $finish;
        end
    end

endmodule
